// File: rtl/arb_pkg.sv
// Shared constants and FSM encoding for the FIFO arbiter slice.
// N_PORTS is assumed to be a power of two so port indices wrap naturally.
package arb_pkg;
  localparam int N_PORTS  = 4;
  localparam int DATA_W   = 6;
  localparam int TH_W     = 5;
  localparam int PTR_W    = $clog2(N_PORTS);
  localparam int DEST_MSB = DATA_W - 1;
  localparam int DEST_LSB = DATA_W - 2;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;
endpackage

// File: rtl/rr_grant.sv
// Picks the first requesting port at or after a base index (round-robin).
// With FIXED_PRIO_EN defined the base is 0 and the pointer ports disappear.
module rr_grant
  import arb_pkg::*;
(
  input  logic [N_PORTS-1:0] i_req,
`ifndef FIXED_PRIO_EN
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [PTR_W-1:0]   o_next_ptr,
`endif
  output logic [N_PORTS-1:0] o_grant,
  output logic [PTR_W-1:0]   o_idx
);
  logic [PTR_W-1:0] w_base;
  logic [PTR_W-1:0] w_pos;
  logic             w_found;

`ifdef FIXED_PRIO_EN
  assign w_base = '0;
`else
  assign w_base     = i_ptr;
  assign o_next_ptr = o_idx + PTR_W'(1);
`endif

  always_comb begin
    w_found = 1'b0;
    w_pos   = '0;
    o_grant = '0;
    o_idx   = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      w_pos = w_base + PTR_W'(k);
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end
endmodule

// File: rtl/fifo_arbiter.sv
// Moves words from four input FIFOs to four output FIFOs by destination field,
// with a 2-stage pop->write pipeline. FIXED_PRIO_EN selects fixed priority.
module fifo_arbiter
  import arb_pkg::*;
(
  input  logic                      clk,
  input  logic                      RESET,
  input  logic                      init,
  input  logic [TH_W-1:0]           th_empty_cfg,
  input  logic [TH_W-1:0]           th_full_cfg,
  input  logic [N_PORTS-1:0]        in_empty,
  input  logic [N_PORTS-1:0]        in_valid,
  input  logic [N_PORTS*DATA_W-1:0] in_data,
  input  logic [N_PORTS-1:0]        out_pause,
  input  logic [N_PORTS-1:0]        out_full,
  output logic [N_PORTS-1:0]        in_rd,
  output logic [N_PORTS-1:0]        out_wr,
  output logic [DATA_W-1:0]         out_data,
  output logic [TH_W-1:0]           al_empty_th,
  output logic [TH_W-1:0]           al_full_th,
  output logic [2:0]                state,
  output logic                      idle,
  output logic                      err_arb
);
  state_t              r_state;
  logic                r_idle;
  logic                r_err;
  logic [TH_W-1:0]     r_th_empty;
  logic [TH_W-1:0]     r_th_full;
  logic                r_s1_valid;
  logic [PTR_W-1:0]    r_s1_idx;
  logic                r_s2_valid;
  logic [DATA_W-1:0]   r_word;

  logic [N_PORTS-1:0]  w_req;
  logic [N_PORTS-1:0]  w_grant;
  logic [PTR_W-1:0]    w_idx;
  logic                w_pop;
  logic [DATA_W-1:0]   w_s1_word;
  logic                w_s1_take;
  logic [PTR_W-1:0]    w_dest;
  logic                w_wr_try;
  logic                w_full_hit;
  logic                w_drained;

  assign w_req = ~in_empty;

`ifdef FIXED_PRIO_EN
  rr_grant u_grant (
    .i_req   (w_req),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );
`else
  logic [PTR_W-1:0] r_rr;
  logic [PTR_W-1:0] w_next_ptr;

  rr_grant u_grant (
    .i_req      (w_req),
    .i_ptr      (r_rr),
    .o_next_ptr (w_next_ptr),
    .o_grant    (w_grant),
    .o_idx      (w_idx)
  );

  always_ff @(posedge clk) begin
    if (RESET)      r_rr <= '0;
    else if (w_pop) r_rr <= w_next_ptr;
  end
`endif

  // Pause and init gate pops combinationally so they take effect the same cycle.
  assign w_pop = (r_state == ST_ACTIVE) && !(|out_pause) && !init && (|w_req);
  assign in_rd = w_pop ? w_grant : '0;

  always_comb begin
    w_s1_word = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (r_s1_idx == PTR_W'(i)) w_s1_word = in_data[i*DATA_W +: DATA_W];
    end
  end

  assign w_s1_take  = r_s1_valid && in_valid[r_s1_idx];
  assign w_dest     = r_word[DEST_MSB:DEST_LSB];
  assign w_wr_try   = r_s2_valid && (r_state == ST_ACTIVE);
  assign w_full_hit = w_wr_try && out_full[w_dest];
  assign out_wr     = (w_wr_try && !out_full[w_dest]) ? (N_PORTS'(1) << w_dest) : '0;
  assign w_drained  = !r_s1_valid && !r_s2_valid;

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_s1_valid <= 1'b0;
      r_s1_idx   <= '0;
      r_s2_valid <= 1'b0;
      r_word     <= '0;
    end else begin
      r_s1_valid <= w_pop;
      if (w_pop) r_s1_idx <= w_idx;
      r_s2_valid <= w_s1_take;
      if (w_s1_take) r_word <= w_s1_word;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state    <= ST_RST;
      r_idle     <= 1'b0;
      r_err      <= 1'b0;
      r_th_empty <= '0;
      r_th_full  <= '0;
    end else begin
      r_idle <= 1'b0;
      case (r_state)
        ST_RST: r_state <= ST_INIT;
        ST_INIT: begin
          r_th_empty <= th_empty_cfg;
          r_th_full  <= th_full_cfg;
          if (!init) begin
            r_state <= ST_IDLE;
            r_idle  <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (init)          r_state <= ST_INIT;
          else if (|w_req)   r_state <= ST_ACTIVE;
          else               r_idle  <= 1'b1;
        end
        ST_ACTIVE: begin
          if (w_full_hit) begin
            r_state <= ST_ERROR;
            r_err   <= 1'b1;
          end else if (init && w_drained) begin
            r_state <= ST_INIT;
          end else if (!(|w_req) && w_drained) begin
            r_state <= ST_IDLE;
            r_idle  <= 1'b1;
          end
        end
        ST_ERROR: r_state <= ST_ERROR;
        default:  r_state <= ST_ERROR;
      endcase
    end
  end

  assign state       = r_state;
  assign idle        = r_idle;
  assign err_arb     = r_err;
  assign al_empty_th = r_th_empty;
  assign al_full_th  = r_th_full;
  assign out_data    = r_word;
endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter: input FIFOs are modelled as queues with
// one-cycle read latency; each scenario task checks its own expectations.
module tb_fifo_arbiter;
  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        init = 1'b0;
  logic [4:0]  th_empty_cfg = '0;
  logic [4:0]  th_full_cfg = '0;
  logic [3:0]  in_empty = 4'hF;
  logic [3:0]  in_valid = '0;
  logic [23:0] in_data = '0;
  logic [3:0]  out_pause = '0;
  logic [3:0]  out_full = '0;
  logic [3:0]  in_rd, out_wr;
  logic [5:0]  out_data;
  logic [4:0]  al_empty_th, al_full_th;
  logic [2:0]  state;
  logic        idle, err_arb;

  logic        drop_valid = 1'b0;
  logic [5:0]  q_in [4][$];
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  fifo_arbiter dut (
    .clk(clk), .RESET(RESET), .init(init),
    .th_empty_cfg(th_empty_cfg), .th_full_cfg(th_full_cfg),
    .in_empty(in_empty), .in_valid(in_valid), .in_data(in_data),
    .out_pause(out_pause), .out_full(out_full),
    .in_rd(in_rd), .out_wr(out_wr), .out_data(out_data),
    .al_empty_th(al_empty_th), .al_full_th(al_full_th),
    .state(state), .idle(idle), .err_arb(err_arb)
  );

  // Input FIFO model: a read pops the head, data/valid appear the next cycle.
  always @(posedge clk) begin : fifo_model
    logic [3:0]  v_valid;
    logic [3:0]  v_empty;
    logic [23:0] v_data;
    v_valid = '0;
    v_empty = '0;
    v_data  = in_data;
    for (int i = 0; i < 4; i++) begin
      if (in_rd[i] && q_in[i].size() > 0) begin
        v_data[i*6 +: 6] = q_in[i].pop_front();
        v_valid[i] = !drop_valid;
      end
      v_empty[i] = (q_in[i].size() == 0);
    end
    in_valid <= v_valid;
    in_data  <= v_data;
    in_empty <= v_empty;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (state !== 3'd0 || idle !== 1'b0 || err_arb !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d idle=%b err=%b, want 0/0/0", state, idle, err_arb);
    end
    n_tests++;
    if (in_rd !== 4'h0 || out_wr !== 4'h0 || out_data !== 6'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: in_rd=%h out_wr=%h out_data=%h, want 0/0/0", in_rd, out_wr, out_data);
    end
    n_tests++;
    if (al_empty_th !== 5'd0 || al_full_th !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_thresholds: empty=%0d full=%0d, want 0/0", al_empty_th, al_full_th);
    end
  endtask

  task automatic test_init();
    RESET = 1'b0; init = 1'b1; th_full_cfg = 5'd6; th_empty_cfg = 5'd2;
    @(negedge clk); #1;
    n_tests++;
    if (state !== 3'd1 || idle !== 1'b0) begin
      n_fail++;
      $display("FAIL init_enter: state=%0d idle=%b, want 1/0", state, idle);
    end
    @(negedge clk); #1;
    n_tests++;
    if (al_full_th !== 5'd6 || al_empty_th !== 5'd2 || state !== 3'd1) begin
      n_fail++;
      $display("FAIL init_thresholds: full=%0d empty=%0d state=%0d, want 6/2/1", al_full_th, al_empty_th, state);
    end
    init = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if (state !== 3'd2 || idle !== 1'b1) begin
      n_fail++;
      $display("FAIL init_to_idle: state=%0d idle=%b, want 2/1", state, idle);
    end
    th_full_cfg = 5'd31; th_empty_cfg = 5'd31;
    @(negedge clk); #1;
    n_tests++;
    if (al_full_th !== 5'd6 || al_empty_th !== 5'd2) begin
      n_fail++;
      $display("FAIL idle_thresholds_hold: full=%0d empty=%0d, want 6/2", al_full_th, al_empty_th);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] rd_log [24];
    logic [3:0] wr_log [24];
    logic [5:0] dat_log [24];
    logic [3:0] exp_oh;
    logic [5:0] exp_word;
    int k0;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 2; j++) q_in[i].push_back({2'(i), 2'(j), 2'b01});
    for (int c = 0; c < 24; c++) begin
      @(negedge clk); #1;
      rd_log[c] = in_rd; wr_log[c] = out_wr; dat_log[c] = out_data;
    end
    k0 = -1;
    for (int c = 23; c >= 0; c--) if (rd_log[c] != 4'h0) k0 = c;
    n_tests++;
    if (k0 < 0 || k0 > 12) begin
      n_fail++;
      $display("FAIL rr_start: first pop at cycle %0d, want 0..12", k0);
      return;
    end
    for (int j = 0; j < 8; j++) begin
      exp_oh   = 4'(1 << (j % 4));
      exp_word = {2'(j % 4), 2'(j / 4), 2'b01};
      n_tests++;
      if (rd_log[k0+j] !== exp_oh) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: in_rd=%b, want %b", j, rd_log[k0+j], exp_oh);
      end
      n_tests++;
      if (wr_log[k0+j+2] !== exp_oh || dat_log[k0+j+2] !== exp_word) begin
        n_fail++;
        $display("FAIL rr_write_%0d: out_wr=%b data=%h, want %b/%h", j, wr_log[k0+j+2], dat_log[k0+j+2], exp_oh, exp_word);
      end
    end
    n_tests++;
    if (rd_log[k0+8] !== 4'h0) begin
      n_fail++;
      $display("FAIL rr_no_extra_pop: in_rd=%b, want 0000", rd_log[k0+8]);
    end
    n_tests++;
    if (state !== 3'd2 || idle !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_back_to_idle: state=%0d idle=%b, want 2/1", state, idle);
    end
  endtask

  task automatic test_routing();
    logic [3:0] rd_log [12];
    logic [3:0] wr_log [12];
    logic [5:0] dat_log [12];
    int k0;
    @(negedge clk);
    q_in[2].push_back(6'b11_0101);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      rd_log[c] = in_rd; wr_log[c] = out_wr; dat_log[c] = out_data;
    end
    k0 = -1;
    for (int c = 11; c >= 0; c--) if (rd_log[c] != 4'h0) k0 = c;
    n_tests++;
    if (k0 < 0 || k0 > 8 || rd_log[k0] !== 4'b0100) begin
      n_fail++;
      $display("FAIL route_pop: cycle %0d, want in_rd=0100 within 8 cycles", k0);
      return;
    end
    n_tests++;
    if (wr_log[k0+1] !== 4'h0) begin
      n_fail++;
      $display("FAIL route_latency: out_wr=%b one cycle after pop, want 0000", wr_log[k0+1]);
    end
    n_tests++;
    if (wr_log[k0+2] !== 4'b1000 || dat_log[k0+2] !== 6'h35) begin
      n_fail++;
      $display("FAIL route_write: out_wr=%b data=%h, want 1000/35", wr_log[k0+2], dat_log[k0+2]);
    end
  endtask

  task automatic test_pause();
    int  wr_cnt, pause_wr, bad_rd, bad_dest;
    bit  found;
    wr_cnt = 0; pause_wr = 0; bad_rd = 0; bad_dest = 0; found = 0;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      q_in[0].push_back({2'b01, 2'(j), 2'b10});
      q_in[1].push_back({2'b01, 2'(j), 2'b11});
    end
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk); #1;
      if (out_wr != 4'h0) wr_cnt++;
      if (in_rd != 4'h0) found = 1;
    end
    // Pointer sits at 3 after the routing test, so the grant wraps to port 0.
    n_tests++;
    if (!found || in_rd !== 4'b0001) begin
      n_fail++;
      $display("FAIL pause_first_grant: found=%0d in_rd=%b, want 0001", found, in_rd);
      return;
    end
    @(negedge clk); #1;
    if (out_wr != 4'h0) wr_cnt++;
    @(negedge clk);
    out_pause = 4'b0010;
    #1;
    n_tests++;
    if (in_rd !== 4'h0) begin
      n_fail++;
      $display("FAIL pause_same_cycle: in_rd=%b, want 0000", in_rd);
    end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (in_rd !== 4'h0) bad_rd++;
      if (out_wr != 4'h0) begin
        pause_wr++;
        if (out_wr !== 4'b0010) bad_dest++;
      end
    end
    n_tests++;
    if (bad_rd != 0 || state !== 3'd3) begin
      n_fail++;
      $display("FAIL pause_hold: pops during pause=%0d state=%0d, want 0/3", bad_rd, state);
    end
    n_tests++;
    if (pause_wr != 2) begin
      n_fail++;
      $display("FAIL pause_inflight: writes during pause=%0d, want 2", pause_wr);
    end
    @(negedge clk);
    out_pause = 4'b0000;
    #1;
    n_tests++;
    if (in_rd === 4'h0) begin
      n_fail++;
      $display("FAIL pause_resume: in_rd=%b, want nonzero", in_rd);
    end
    for (int c = 0; c < 15; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (out_wr != 4'h0) begin
        wr_cnt++;
        if (out_wr !== 4'b0010) bad_dest++;
      end
    end
    n_tests++;
    if (wr_cnt + pause_wr != 6 || bad_dest != 0) begin
      n_fail++;
      $display("FAIL pause_total: writes=%0d bad_dest=%0d, want 6/0", wr_cnt + pause_wr, bad_dest);
    end
    n_tests++;
    if (state !== 3'd2) begin
      n_fail++;
      $display("FAIL pause_drain_idle: state=%0d, want 2", state);
    end
  endtask

  task automatic test_missing_valid();
    int  wr_cnt;
    bit  found;
    wr_cnt = 0; found = 0;
    @(negedge clk);
    drop_valid = 1'b1;
    q_in[3].push_back(6'b00_0001);
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk); #1;
      if (in_rd != 4'h0) found = 1;
    end
    n_tests++;
    if (!found || in_rd !== 4'b1000) begin
      n_fail++;
      $display("FAIL novalid_pop: found=%0d in_rd=%b, want 1000", found, in_rd);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (out_wr != 4'h0) wr_cnt++;
    end
    drop_valid = 1'b0;
    n_tests++;
    if (wr_cnt != 0 || err_arb !== 1'b0 || state !== 3'd2) begin
      n_fail++;
      $display("FAIL novalid_nowrite: writes=%0d err=%b state=%0d, want 0/0/2", wr_cnt, err_arb, state);
    end
  endtask

  task automatic test_init_return();
    @(negedge clk);
    init = 1'b1; th_full_cfg = 5'd9; th_empty_cfg = 5'd3;
    @(negedge clk); #1;
    n_tests++;
    if (state !== 3'd1 || idle !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_to_init: state=%0d idle=%b, want 1/0", state, idle);
    end
    init = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if (state !== 3'd2 || al_full_th !== 5'd9 || al_empty_th !== 5'd3) begin
      n_fail++;
      $display("FAIL reinit_thresholds: state=%0d full=%0d empty=%0d, want 2/9/3", state, al_full_th, al_empty_th);
    end
  endtask

  task automatic test_full_error();
    int  bad;
    bit  found;
    bad = 0; found = 0;
    @(negedge clk);
    out_full = 4'b0001;
    q_in[0].push_back(6'b00_1010);
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk); #1;
      if (in_rd != 4'h0) found = 1;
    end
    n_tests++;
    if (!found || in_rd !== 4'b0001) begin
      n_fail++;
      $display("FAIL err_pop: found=%0d in_rd=%b, want 0001", found, in_rd);
    end
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (out_wr !== 4'h0) begin
      n_fail++;
      $display("FAIL err_suppress: out_wr=%b at write stage, want 0000", out_wr);
    end
    @(negedge clk); #1;
    n_tests++;
    if (err_arb !== 1'b1 || state !== 3'd4) begin
      n_fail++;
      $display("FAIL err_enter: err=%b state=%0d, want 1/4", err_arb, state);
    end
    q_in[1].push_back(6'b01_1111);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      if (in_rd !== 4'h0 || out_wr !== 4'h0) bad++;
    end
    n_tests++;
    if (bad != 0 || err_arb !== 1'b1 || state !== 3'd4) begin
      n_fail++;
      $display("FAIL err_hold: activity=%0d err=%b state=%0d, want 0/1/4", bad, err_arb, state);
    end
    out_full = 4'b0000;
  endtask

  task automatic test_reset_recovery();
    @(negedge clk);
    RESET = 1'b1;
    q_in[1].delete();
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (state !== 3'd0 || err_arb !== 1'b0 || in_rd !== 4'h0 || out_data !== 6'h0) begin
      n_fail++;
      $display("FAIL rerst_clear: state=%0d err=%b in_rd=%b data=%h, want 0/0/0000/00", state, err_arb, in_rd, out_data);
    end
    n_tests++;
    if (al_full_th !== 5'd0 || al_empty_th !== 5'd0 || idle !== 1'b0) begin
      n_fail++;
      $display("FAIL rerst_thresholds: full=%0d empty=%0d idle=%b, want 0/0/0", al_full_th, al_empty_th, idle);
    end
    RESET = 1'b0; init = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (state !== 3'd2 || idle !== 1'b1) begin
      n_fail++;
      $display("FAIL rerst_idle: state=%0d idle=%b, want 2/1", state, idle);
    end
  endtask

`ifdef FIXED_PRIO_EN
  task automatic test_fixed_prio();
    logic [3:0] rd_log [16];
    logic [3:0] exp_seq [4];
    int k0;
    exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b1000;
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      q_in[1].push_back({2'b01, 2'(j), 2'b00});
      q_in[3].push_back({2'b11, 2'(j), 2'b00});
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk); #1;
      rd_log[c] = in_rd;
    end
    k0 = -1;
    for (int c = 15; c >= 0; c--) if (rd_log[c] != 4'h0) k0 = c;
    n_tests++;
    if (k0 < 0 || k0 > 10) begin
      n_fail++;
      $display("FAIL fixed_start: first pop at cycle %0d, want 0..10", k0);
      return;
    end
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if (rd_log[k0+j] !== exp_seq[j]) begin
        n_fail++;
        $display("FAIL fixed_grant_%0d: in_rd=%b, want %b", j, rd_log[k0+j], exp_seq[j]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_init();
`ifdef FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_round_robin();
    test_routing();
    test_pause();
`endif
    test_missing_valid();
    test_init_return();
    test_full_error();
    test_reset_recovery();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
